spi_frame_rx: RTL and testbench
===============================

Name: spi_frame_rx

Overview:
Upstream input stage of the CNN system. It receives one image frame from the external host over the SPI slave pins, which are asynchronous to clk. It assembles the bit stream into bytes and writes them sequentially into the image frame buffer. When a complete frame has arrived, it hands the frame to the CNN controller through a done/ack handshake.

Parameters:
FRAME_BYTES, 1024, bytes per frame (32x32 8-bit pixels)
ADDR_W, 10, frame buffer address width; must satisfy 2**ADDR_W >= FRAME_BYTES
SYNC_STAGES, 2, synchronizer flops on each SPI input pin

Ports:
clk  in  1  system clock (100 MHz)
rst_n  in  1  synchronous active-low reset
spi_slave_sclk  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0)
spi_slave_mosi  in  1  SPI data in, MSB first
spi_slave_ss  in  1  SPI select, active-low
spi_slave_miso  out  1  status byte out, MSB first
buf_we  out  1  frame buffer write strobe, one-cycle pulse per byte
buf_addr  out  ADDR_W  frame buffer write address
buf_wdata  out  8  received byte
frame_done  out  1  level; a complete frame is in the buffer
frame_ack  in  1  controller has consumed the frame
frame_err  out  1  one-cycle pulse on an aborted or malformed frame
rx_busy  out  1  high in RECV

Behaviour:
- Reset is synchronous and active-low. Clock is clk, reset is rst_n.
- Reset values: all outputs 0, state IDLE, byte count 0, bit count 0, sticky error bit 0. Synchronizer flops reset to SCLK=0, SS=1, MOSI=0.
- Input capture: each SPI pin passes through SYNC_STAGES flops, then one edge-detect flop.
  - sclk_rise/sclk_fall are single-cycle pulses, and ss_fall/ss_rise likewise.
  - Pin-to-pulse latency is SYNC_STAGES+1 clk.
  - Supported SCLK half-period is at least 4 clk cycles.
- States: IDLE, RECV, DONE.
- IDLE:
  - ss_fall resets the bit and byte counts and moves to RECV.
  - SCLK edges are ignored.
- RECV:
  - On sclk_rise, synced MOSI shifts into bit 0 of the shift register (MSB first) and the bit count increments.
  - On the 8th bit, the next clk presents buf_we=1 with buf_addr=byte count and buf_wdata=assembled byte. The byte count then increments.
  - Once the byte count reaches FRAME_BYTES, further bytes are discarded (no buf_we) and the overflow condition is recorded.
- End of frame (ss_rise in RECV):
  - If byte count == FRAME_BYTES and bit count == 0 and no overflow: go to DONE.
  - Otherwise (short frame, partial byte, or overflow): pulse frame_err for 1 clk, set the sticky error bit, and return to IDLE.
- DONE:
  - frame_done is held high.
  - All SPI activity is ignored: no writes, and an SS cycle does not start a new frame.
  - frame_ack while in DONE clears frame_done on the next clk and moves to IDLE. A new SS edge is accepted from that point.
  - frame_ack outside DONE is ignored.
- Simultaneous events: ss_rise in the same clk as the 8th sclk_rise completes and writes that byte first, then evaluates the end-of-frame conditions.
- MISO:
  - While SS is low, outputs status byte {frame_done, sticky_err, 6'b0}, MSB first.
  - The status byte is loaded on ss_fall and shifted on each sclk_fall.
  - Drives 0 while SS is high.
  - The sticky error bit clears on the next ss_fall after it has been shifted out.
- Reset mid-frame: returns to IDLE immediately. No frame_done or frame_err is produced. Partial buffer contents are left undefined.

Optional Feature:
- Macro: SPI_FRAME_RX_CHECKSUM_EN.
- When defined:
  - The frame is FRAME_BYTES data bytes plus one trailing checksum byte.
  - The checksum byte is not written to the buffer.
  - Expected checksum is the 8-bit sum mod 256 of all data bytes.
  - On a mismatch at ss_rise: frame_err, sticky error set, return to IDLE.
- When undefined: no checksum byte is expected, and a trailing extra byte counts as overflow.

Decomposition:
- Package cnn_spi_pkg holds:
  - state enum rx_state_e {IDLE, RECV, DONE}
  - FRAME_BYTES_DEFAULT = 1024
  - STATUS_DONE_BIT = 7, STATUS_ERR_BIT = 6
- Sub-module spi_sync_edge: a parameterised SYNC_STAGES synchronizer plus edge detector. It is instantiated once each for SCLK and SS; MOSI uses the synchronizer path only.

Test Plan:
- Reset, then 1024 bytes with values i mod 256, SCLK at 1 MHz -> 1024 buf_we pulses, addr 0..1023, data matches; frame_done=1 after ss_rise; frame_ack -> frame_done=0 next clk, state IDLE.
- 10 bytes 0xAA..0xB3, then SS high -> 10 writes at addr 0..9, frame_err single pulse, frame_done stays 0; the next SS cycle reads MISO=0x40.
- 1024 bytes plus 3 extra bits, then SS high -> frame_err pulse, no frame_done.
- In DONE without ack, send another 5-byte SS cycle -> no buf_we; MISO reads 0x80; frame_done stays 1.
- rst_n low for 1 clk after byte 500 -> all outputs 0 next clk, no frame_err; a following full frame completes normally with addr starting at 0.
- With SPI_FRAME_RX_CHECKSUM_EN: all-0x01 frame plus checksum 0x00 -> frame_done; repeat with checksum 0x01 -> frame_err, no frame_done.

Source files
------------

// File: rtl/cnn_spi_pkg.sv
// Shared types and constants for the SPI frame receive path.
package cnn_spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } rx_state_e;

  localparam int unsigned FRAME_BYTES_DEFAULT = 1024;
  localparam int unsigned STATUS_DONE_BIT     = 7;
  localparam int unsigned STATUS_ERR_BIT      = 6;

  // Status byte returned on MISO during an SS cycle.
  function automatic logic [7:0] status_byte(input logic done, input logic err);
    logic [7:0] s;
    s                  = '0;
    s[STATUS_DONE_BIT] = done;
    s[STATUS_ERR_BIT]  = err;
    return s;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer plus edge detector for one asynchronous SPI pin.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise_c,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchronizer chain followed by one flop holding the previous synced level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= SYNC_STAGES'({sync_q, din});
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_c = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_frame_rx.sv
// SPI slave frame receiver: assembles MOSI bytes into the frame buffer and
// hands a complete frame to the CNN controller via frame_done/frame_ack.
// Optional trailing checksum byte enabled by SPI_FRAME_RX_CHECKSUM_EN.
module spi_frame_rx
  import cnn_spi_pkg::*;
#(
  parameter int unsigned FRAME_BYTES = FRAME_BYTES_DEFAULT,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_slave_sclk,
  input  logic              spi_slave_mosi,
  input  logic              spi_slave_ss,
  output logic              spi_slave_miso,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [7:0]        buf_wdata,
  output logic              frame_done,
  input  logic              frame_ack,
  output logic              frame_err,
  output logic              rx_busy
);

  localparam int unsigned CNT_W = ADDR_W + 1;
`ifdef SPI_FRAME_RX_CHECKSUM_EN
  localparam int unsigned TOTAL_BYTES = FRAME_BYTES + 1;
`else
  localparam int unsigned TOTAL_BYTES = FRAME_BYTES;
`endif

  logic sclk_rise_c, sclk_fall_c, ss_rise_c, ss_fall_c;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   mosi_s;

  rx_state_e        state_q;
  logic [2:0]       bit_cnt_q;
  logic [CNT_W-1:0] byte_cnt_q;
  logic [6:0]       shift_q;
  logic             ovf_q;
  logic             sticky_q;
  logic             err_shown_q;
  logic             ss_low_q;
  logic [6:0]       miso_sr_q;
`ifdef SPI_FRAME_RX_CHECKSUM_EN
  logic [7:0]       csum_q;
  logic [7:0]       csum_rx_q;
  logic             csum_slot_c;
  logic             csum_ok_c;
`endif

  logic             byte_fire_c;
  logic [7:0]       byte_val_c;
  logic             data_slot_c;
  logic             ovf_hit_c;
  logic [2:0]       bit_cnt_eff_c;
  logic [CNT_W-1:0] byte_cnt_eff_c;
  logic             frame_ok_c;
  logic [7:0]       status_c;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (spi_slave_sclk),
    .rise_c (sclk_rise_c),
    .fall_c (sclk_fall_c)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (spi_slave_ss),
    .rise_c (ss_rise_c),
    .fall_c (ss_fall_c)
  );

  // MOSI only needs a synchronized level, sampled on sclk_rise.
  always_ff @(posedge clk) begin
    if (!rst_n) mosi_q <= '0;
    else        mosi_q <= SYNC_STAGES'({mosi_q, spi_slave_mosi});
  end
  assign mosi_s = mosi_q[SYNC_STAGES-1];

  // Post-edge counts so an SS rise coinciding with the 8th bit sees that byte.
  always_comb begin
    byte_fire_c    = (state_q == RECV) && sclk_rise_c && (bit_cnt_q == 3'd7);
    byte_val_c     = {shift_q, mosi_s};
    data_slot_c    = byte_fire_c && (byte_cnt_q < CNT_W'(FRAME_BYTES));
    ovf_hit_c      = byte_fire_c && (byte_cnt_q >= CNT_W'(TOTAL_BYTES));
    bit_cnt_eff_c  = bit_cnt_q + 3'((state_q == RECV) && sclk_rise_c);
    byte_cnt_eff_c = byte_cnt_q + CNT_W'(byte_fire_c && !ovf_hit_c);
    frame_ok_c     = (byte_cnt_eff_c == CNT_W'(TOTAL_BYTES)) &&
                     (bit_cnt_eff_c == 3'd0) && !(ovf_q || ovf_hit_c);
`ifdef SPI_FRAME_RX_CHECKSUM_EN
    csum_slot_c    = byte_fire_c && (byte_cnt_q == CNT_W'(FRAME_BYTES));
    csum_ok_c      = csum_slot_c ? (byte_val_c == csum_q) : (csum_rx_q == csum_q);
    frame_ok_c     = frame_ok_c && csum_ok_c;
`endif
    status_c       = status_byte(frame_done, err_shown_q ? 1'b0 : sticky_q);
  end

  // Frame FSM, buffer write port, status shifter and sticky error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      byte_cnt_q     <= '0;
      shift_q        <= '0;
      ovf_q          <= 1'b0;
      sticky_q       <= 1'b0;
      err_shown_q    <= 1'b0;
      ss_low_q       <= 1'b0;
      miso_sr_q      <= '0;
      spi_slave_miso <= 1'b0;
      buf_we         <= 1'b0;
      buf_addr       <= '0;
      buf_wdata      <= '0;
      frame_done     <= 1'b0;
      frame_err      <= 1'b0;
      rx_busy        <= 1'b0;
`ifdef SPI_FRAME_RX_CHECKSUM_EN
      csum_q         <= '0;
      csum_rx_q      <= '0;
`endif
    end else begin
      buf_we    <= 1'b0;
      frame_err <= 1'b0;

      // Status byte loads on every SS fall, regardless of frame state.
      if (ss_fall_c) begin
        ss_low_q       <= 1'b1;
        miso_sr_q      <= status_c[6:0];
        spi_slave_miso <= status_c[7];
        if (err_shown_q) begin
          sticky_q    <= 1'b0;
          err_shown_q <= 1'b0;
        end else begin
          err_shown_q <= sticky_q;
        end
      end else if (ss_rise_c) begin
        ss_low_q       <= 1'b0;
        spi_slave_miso <= 1'b0;
      end else if (ss_low_q && sclk_fall_c) begin
        miso_sr_q      <= {miso_sr_q[5:0], 1'b0};
        spi_slave_miso <= miso_sr_q[6];
      end

      case (state_q)
        IDLE: begin
          if (ss_fall_c) begin
            state_q    <= RECV;
            rx_busy    <= 1'b1;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            ovf_q      <= 1'b0;
`ifdef SPI_FRAME_RX_CHECKSUM_EN
            csum_q     <= '0;
            csum_rx_q  <= '0;
`endif
          end
        end
        RECV: begin
          if (sclk_rise_c) begin
            shift_q   <= byte_val_c[6:0];
            bit_cnt_q <= bit_cnt_eff_c;
          end
          if (data_slot_c) begin
            buf_we    <= 1'b1;
            buf_addr  <= ADDR_W'(byte_cnt_q);
            buf_wdata <= byte_val_c;
`ifdef SPI_FRAME_RX_CHECKSUM_EN
            csum_q    <= csum_q + byte_val_c;
`endif
          end
`ifdef SPI_FRAME_RX_CHECKSUM_EN
          if (csum_slot_c) csum_rx_q <= byte_val_c;
`endif
          if (ovf_hit_c) ovf_q <= 1'b1;
          byte_cnt_q <= byte_cnt_eff_c;
          if (ss_rise_c) begin
            rx_busy <= 1'b0;
            if (frame_ok_c) begin
              state_q    <= DONE;
              frame_done <= 1'b1;
            end else begin
              state_q     <= IDLE;
              frame_err   <= 1'b1;
              sticky_q    <= 1'b1;
              err_shown_q <= 1'b0;
            end
          end
        end
        DONE: begin
          if (frame_ack) begin
            state_q    <= IDLE;
            frame_done <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench for spi_frame_rx with a reduced 16-byte frame.
module tb_spi_frame_rx;

  localparam int FB   = 16;
  localparam int AW   = 4;
  localparam int HALF = 4;

  logic          clk;
  logic          rst_n;
  logic          sclk, mosi, ss, miso;
  logic          buf_we;
  logic [AW-1:0] buf_addr;
  logic [7:0]    buf_wdata;
  logic          frame_done, frame_ack, frame_err, rx_busy;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            err_pulses = 0;
  logic [AW-1:0] wr_addr_q[$];
  logic [7:0]    wr_data_q[$];
  logic [7:0]    rx_status;

  spi_frame_rx #(.FRAME_BYTES(FB), .ADDR_W(AW), .SYNC_STAGES(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .spi_slave_sclk (sclk),
    .spi_slave_mosi (mosi),
    .spi_slave_ss   (ss),
    .spi_slave_miso (miso),
    .buf_we         (buf_we),
    .buf_addr       (buf_addr),
    .buf_wdata      (buf_wdata),
    .frame_done     (frame_done),
    .frame_ack      (frame_ack),
    .frame_err      (frame_err),
    .rx_busy        (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log buffer writes and error pulses away from the active edge.
  always @(negedge clk) begin
    if (buf_we) begin
      wr_addr_q.push_back(buf_addr);
      wr_data_q.push_back(buf_wdata);
    end
    if (frame_err) err_pulses++;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int i, input logic [7:0] base, input logic [7:0] step);
    return 8'(base + 8'(i) * step);
  endfunction

  function automatic logic [7:0] csum(input int n, input logic [7:0] base, input logic [7:0] step);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < n; i++) s = s + pat(i, base, step);
    return s;
  endfunction

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    err_pulses = 0;
  endtask

  task automatic check_writes(input string tag, input int n, input logic [7:0] base,
                              input logic [7:0] step);
    int bad;
    bad = 0;
    check({tag, "_wr_cnt"}, 32'(wr_addr_q.size()), 32'(n));
    for (int i = 0; i < n && i < wr_addr_q.size(); i++)
      if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== pat(i, base, step)) bad++;
    check({tag, "_wr_bad"}, 32'(bad), 32'd0);
  endtask

  // Mode 0 master: MOSI set while SCLK low, MISO sampled just before the rise.
  task automatic spi_bits(input logic [7:0] b, input int n);
    rx_status = '0;
    for (int i = 0; i < n; i++) begin
      mosi = b[7-i];
      repeat (HALF) @(negedge clk);
      rx_status = {rx_status[6:0], miso};
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic send_bytes(input int n, input logic [7:0] base, input logic [7:0] step);
    for (int i = 0; i < n; i++) spi_bits(pat(i, base, step), 8);
  endtask

  task automatic send_frame(input logic [7:0] base, input logic [7:0] step);
    send_bytes(FB, base, step);
`ifdef SPI_FRAME_RX_CHECKSUM_EN
    spi_bits(csum(FB, base, step), 8);
`endif
  endtask

  task automatic ss_begin();
    @(negedge clk);
    ss = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic ss_end();
    repeat (HALF) @(negedge clk);
    ss = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_ack();
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0; ss = 1'b1; frame_ack = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_outputs",
          32'({buf_we, buf_addr, buf_wdata, frame_done, frame_err, rx_busy, miso}), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Full frame of i mod 256.
    clear_log();
    ss_begin();
    check("busy_in_recv", 32'(rx_busy), 32'd1);
    send_frame(8'h00, 8'h01);
    ss_end();
    check_writes("full1", FB, 8'h00, 8'h01);
    check("full1_done", 32'(frame_done), 32'd1);
    check("full1_err", 32'(err_pulses), 32'd0);
    check("full1_busy", 32'(rx_busy), 32'd0);

    // SPI activity while DONE is ignored; status shows done.
    clear_log();
    ss_begin();
    spi_bits(8'h5A, 8);
    check("done_status", 32'(rx_status), 32'h80);
    send_bytes(4, 8'h11, 8'h01);
    ss_end();
    check("done_no_wr", 32'(wr_addr_q.size()), 32'd0);
    check("done_hold", 32'(frame_done), 32'd1);
    check("done_no_err", 32'(err_pulses), 32'd0);

    do_ack();
    check("ack_clears_done", 32'(frame_done), 32'd0);
    do_ack();
    check("ack_idle_ignored", 32'(frame_done), 32'd0);

    // Short frame of 10 bytes.
    clear_log();
    ss_begin();
    send_bytes(10, 8'hAA, 8'h01);
    ss_end();
    check_writes("short", 10, 8'hAA, 8'h01);
    check("short_err", 32'(err_pulses), 32'd1);
    check("short_done", 32'(frame_done), 32'd0);

    // Status read shows the sticky error; the read cycle itself is a short frame.
    clear_log();
    ss_begin();
    spi_bits(8'h00, 8);
    check("err_status", 32'(rx_status), 32'h40);
    ss_end();
    check_writes("stat_rd", 1, 8'h00, 8'h00);
    check("stat_rd_err", 32'(err_pulses), 32'd1);

    // Full frame plus 3 trailing bits.
    clear_log();
    ss_begin();
    send_frame(8'h00, 8'h01);
    spi_bits(8'hE0, 3);
    ss_end();
    check_writes("partial", FB, 8'h00, 8'h01);
    check("partial_err", 32'(err_pulses), 32'd1);
    check("partial_done", 32'(frame_done), 32'd0);

    // Two bytes beyond the expected frame length.
    clear_log();
    ss_begin();
    send_bytes(FB + 2, 8'h00, 8'h01);
    ss_end();
    check_writes("ovf", FB, 8'h00, 8'h01);
    check("ovf_err", 32'(err_pulses), 32'd1);
    check("ovf_done", 32'(frame_done), 32'd0);

    // Reset in mid-frame, then a clean frame from address 0.
    clear_log();
    ss_begin();
    send_bytes(8, 8'h00, 8'h01);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_outputs",
          32'({buf_we, buf_addr, buf_wdata, frame_done, frame_err, rx_busy, miso}), 32'd0);
    rst_n = 1'b1;
    ss = 1'b1;
    repeat (12) @(negedge clk);
    check_writes("midrst", 8, 8'h00, 8'h01);
    check("midrst_err", 32'(err_pulses), 32'd0);
    check("midrst_state", 32'({frame_done, rx_busy}), 32'd0);

    clear_log();
    ss_begin();
    send_frame(8'h30, 8'h03);
    ss_end();
    check_writes("full2", FB, 8'h30, 8'h03);
    check("full2_done", 32'(frame_done), 32'd1);
    check("full2_err", 32'(err_pulses), 32'd0);
    ss_begin();
    spi_bits(8'h00, 8);
    ss_end();
    check("full2_status", 32'(rx_status), 32'h80);
    do_ack();
    check("full2_ack", 32'(frame_done), 32'd0);

`ifdef SPI_FRAME_RX_CHECKSUM_EN
    // All-0x01 frame with correct then incorrect checksum.
    clear_log();
    ss_begin();
    send_bytes(FB, 8'h01, 8'h00);
    spi_bits(8'h10, 8);
    ss_end();
    check_writes("cs_ok", FB, 8'h01, 8'h00);
    check("cs_ok_done", 32'(frame_done), 32'd1);
    check("cs_ok_err", 32'(err_pulses), 32'd0);
    do_ack();

    clear_log();
    ss_begin();
    send_bytes(FB, 8'h01, 8'h00);
    spi_bits(8'h11, 8);
    ss_end();
    check("cs_bad_err", 32'(err_pulses), 32'd1);
    check("cs_bad_done", 32'(frame_done), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
